// File: rtl/mul_pkg.sv
// Shared types and sizing helpers for the seq_multiplier slice.
// The signed datapath is compiled in only when SEQ_MUL_SIGNED_EN is defined.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } mul_state_e;

  localparam int MUL_MIN_WIDTH = 2;
  localparam int MUL_MAX_WIDTH = 32;

  // Step counter width: enough bits to count 0..width.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_ripple_adder.sv
// N-bit ripple-carry adder/subtractor built from a chain of full-adder cells.
// sub_i=1 computes a_i - b_i by inverting b_i and injecting a carry-in of 1.
module mul_ripple_adder #(
  parameter int N = 9
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         sub_i,
  output logic [N-1:0] sum_o,
  output logic         cout_o
);

  logic [N:0]   carry;
  logic [N-1:0] b_eff;

  assign b_eff    = b_i ^ {N{sub_i}};
  assign carry[0] = sub_i;

  for (genvar i = 0; i < N; i++) begin : g_fa
    logic p;
    assign p          = a_i[i] ^ b_eff[i];
    assign sum_o[i]   = p ^ carry[i];
    assign carry[i+1] = (a_i[i] & b_eff[i]) | (carry[i] & p);
  end

  assign cout_o = carry[N];

endmodule

// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier: one WIDTH+1 bit adder reused over WIDTH steps.
// Define SEQ_MUL_SIGNED_EN to enable two's-complement operation via signed_mode.
module seq_multiplier
  import mul_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int AW    = WIDTH + 1;

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; ready/valid here are decoded purely from the registered state.

  mul_state_e         state_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [AW-1:0]      acc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               sgn_q;
  logic [2*WIDTH-1:0] product_q;

  logic sgn_in;
`ifdef SEQ_MUL_SIGNED_EN
  assign sgn_in = signed_mode;
`else
  logic unused_signed_mode;
  assign unused_signed_mode = signed_mode;
  assign sgn_in             = 1'b0;
`endif

  logic             last_step;
  logic             step_bit;
  logic             step_sub;
  logic [AW-1:0]    addend;
  logic [AW-1:0]    step_sum;
  logic [AW-1:0]    acc_d;
  logic [WIDTH-1:0] mplier_d;
  logic             unused_cout;

  // The multiplier MSB carries negative weight in signed mode, hence the subtract.
  always_comb begin
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    step_bit  = mplier_q[0];
    step_sub  = sgn_q & last_step & step_bit;
    addend    = '0;
    if (step_bit) begin
      addend = {sgn_q & mcand_q[WIDTH-1], mcand_q};
    end
    acc_d    = {sgn_q & step_sum[AW-1], step_sum[AW-1:1]};
    mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
  end

  mul_ripple_adder #(
    .N(AW)
  ) u_adder (
    .a_i   (acc_q),
    .b_i   (addend),
    .sub_i (step_sub),
    .sum_o (step_sum),
    .cout_o(unused_cout)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      mplier_q  <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      sgn_q     <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mcand_q  <= a;
            mplier_q <= b;
            sgn_q    <= sgn_in;
            acc_q    <= '0;
            cnt_q    <= '0;
            state_q  <= CALC;
          end
        end
        CALC: begin
          acc_q    <= acc_d;
          mplier_q <= mplier_d;
          cnt_q    <= cnt_q + CNT_W'(1);
          if (last_step) begin
            // Low product bits have been shifted into the multiplier register.
            product_q <= {acc_d[WIDTH-1:0], mplier_d};
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign product   = product_q;

endmodule
